// File: rtl/rtc_lector_digitos_if.sv
// Multiplexed RTC address/data bus seen from the reader (master) and the RTC (slave).
interface rtc_lector_digitos_if;
  logic [7:0] ad_out;
  logic       ad_oe;
  logic [7:0] ad_in;
  logic       a_d;
  logic       cs_n;
  logic       wr_n;
  logic       rd_n;

  modport master (output ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, input ad_in);
  modport slave  (input ad_out, ad_oe, a_d, cs_n, wr_n, rd_n, output ad_in);
endinterface

// File: rtl/rtc_lector_digitos.sv
// RTC sweep reader: reads the nine time/date/timer registers over the
// multiplexed bus into a shadow buffer, then publishes every display digit in
// one cycle so the screen never shows a half-updated time.
module rtc_lector_digitos #(
  parameter int T_PULSO = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 leer,
  rtc_lector_digitos_if.master bus,
  output logic [3:0]           digit0_SS,   digit1_SS,
  output logic [3:0]           digit0_MM,   digit1_MM,
  output logic [3:0]           digit0_HH,   digit1_HH,
  output logic [3:0]           digit0_DAY,  digit1_DAY,
  output logic [3:0]           digit0_MES,  digit1_MES,
  output logic [3:0]           digit0_YEAR, digit1_YEAR,
  output logic [3:0]           digit0_SS_T, digit1_SS_T,
  output logic [3:0]           digit0_MM_T, digit1_MM_T,
  output logic [3:0]           digit0_HH_T, digit1_HH_T,
  output logic                 AM_PM,
  output logic                 formato_hora,
  output logic                 hecho
);
  localparam int CW = (T_PULSO > 1) ? $clog2(T_PULSO) : 1;

  typedef enum logic [2:0] {IDLE, A_SET, A_WR, A_HOLD, TURN, D_RD, D_END, COMMIT} state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            last;
  logic [3:0]      index;
  logic [8:0][7:0] shadow;
  logic [7:0]      addr;

  assign last = (cnt == CW'(T_PULSO - 1));
  // 21h..26h for the clock/date, 41h..43h for the timer
  assign addr = (index < 4'd6) ? (8'h21 + {4'h0, index}) : (8'h3B + {4'h0, index});

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // next-state logic; strobe phases last T_PULSO cycles
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (leer) state_nx = A_SET;
      A_SET:   state_nx = A_WR;
      A_WR:    if (last) state_nx = A_HOLD;
      A_HOLD:  state_nx = TURN;
      TURN:    state_nx = D_RD;
      D_RD:    if (last) state_nx = D_END;
      D_END:   state_nx = (index == 4'd8) ? COMMIT : A_SET;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // bus strobes decoded from state; ad_oe is never high while rd_n is low
  always_comb begin
    bus.cs_n   = 1'b1;
    bus.wr_n   = 1'b1;
    bus.rd_n   = 1'b1;
    bus.ad_oe  = 1'b0;
    bus.a_d    = 1'b1;
    bus.ad_out = 8'h00;
    case (state)
      A_SET, A_HOLD: begin
        bus.cs_n = 1'b0; bus.a_d = 1'b0; bus.ad_oe = 1'b1; bus.ad_out = addr;
      end
      A_WR: begin
        bus.cs_n = 1'b0; bus.a_d = 1'b0; bus.ad_oe = 1'b1; bus.ad_out = addr;
        bus.wr_n = 1'b0;
      end
      TURN:    bus.cs_n = 1'b0;
      D_RD:    begin bus.cs_n = 1'b0; bus.rd_n = 1'b0; end
      default: ;
    endcase
    hecho = (state == COMMIT);
  end

  // strobe width counter, register index and shadow capture
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt    <= '0;
      index  <= '0;
      shadow <= '0;
    end else begin
      if ((state == A_WR || state == D_RD) && !last) cnt <= cnt + 1'b1;
      else                                           cnt <= '0;
      if (state == IDLE && leer)  index <= '0;
      else if (state == D_END)    index <= (index == 4'd8) ? 4'd0 : index + 4'd1;
      if (state == D_RD && last)  shadow[index] <= bus.ad_in;
    end
  end

  // publish all digits at once as the sweep commits (visible during COMMIT)
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      {digit0_SS, digit1_SS, digit0_MM, digit1_MM, digit0_HH, digit1_HH}             <= '0;
      {digit0_DAY, digit1_DAY, digit0_MES, digit1_MES, digit0_YEAR, digit1_YEAR}     <= '0;
      {digit0_SS_T, digit1_SS_T, digit0_MM_T, digit1_MM_T, digit0_HH_T, digit1_HH_T} <= '0;
      AM_PM        <= 1'b0;
      formato_hora <= 1'b0;
    end else if (state == D_END && index == 4'd8) begin
      digit0_SS    <= shadow[0][3:0];  digit1_SS    <= {1'b0, shadow[0][6:4]};
      digit0_MM    <= shadow[1][3:0];  digit1_MM    <= {1'b0, shadow[1][6:4]};
      digit0_HH    <= shadow[2][3:0];
      // bit 7 selects 12 h mode, where bit 5 becomes the PM flag
      digit1_HH    <= shadow[2][7] ? {3'b000, shadow[2][4]} : {2'b00, shadow[2][5:4]};
      AM_PM        <= shadow[2][7] & shadow[2][5];
      formato_hora <= shadow[2][7];
      digit0_DAY   <= shadow[3][3:0];  digit1_DAY   <= {2'b00, shadow[3][5:4]};
      digit0_MES   <= shadow[4][3:0];  digit1_MES   <= {3'b000, shadow[4][4]};
      digit0_YEAR  <= shadow[5][3:0];  digit1_YEAR  <= shadow[5][7:4];
      digit0_SS_T  <= shadow[6][3:0];  digit1_SS_T  <= {1'b0, shadow[6][6:4]};
      digit0_MM_T  <= shadow[7][3:0];  digit1_MM_T  <= {1'b0, shadow[7][6:4]};
      digit0_HH_T  <= shadow[8][3:0];  digit1_HH_T  <= {2'b00, shadow[8][5:4]};
    end
  end
endmodule

// File: tb/tb_rtc_lector_digitos.sv
// Bench for rtc_lector_digitos: an RTC register model answers the bus, the
// stimulus queues the display it expects per sweep, and a negedge monitor
// checks bus timing, sweep length and the committed display.
module tb_rtc_lector_digitos;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic leer = 1'b0;
  logic leer_x = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [17:0][3:0] d;   // pairs digit0/digit1 of SS,MM,HH,DAY,MES,YEAR,SS_T,MM_T,HH_T
    logic             ampm;
    logic             fmt;
  } disp_t;

  logic [8:0][7:0] mem = '0;
  disp_t expq[$];
  disp_t shown;
  int    tests = 0, fails = 0, timeouts = 0;
  bit    done = 0;

  function automatic int idx_of(input logic [7:0] a);
    if (a >= 8'h21 && a <= 8'h26) return int'(a) - 'h21;
    if (a >= 8'h41 && a <= 8'h43) return int'(a) - 'h41 + 6;
    return 0;
  endfunction

  function automatic logic [7:0] addr_of(input int i);
    logic [7:0] a;
    a = (i < 6) ? 8'(32'h21 + i) : 8'(32'h41 + i - 6);
    return a;
  endfunction

  // Display the RTC bytes should produce, from the BCD field rules
  function automatic disp_t model(input logic [8:0][7:0] r);
    disp_t e;
    int b;
    e = '0;
    for (int i = 0; i < 9; i++) e.d[2*i] = 4'(int'(r[i]) % 16);
    e.d[1]  = 4'((int'(r[0]) / 16) % 8);
    e.d[3]  = 4'((int'(r[1]) / 16) % 8);
    b = int'(r[2]);
    e.fmt = (b >= 128);
    if (e.fmt) begin
      e.d[5] = 4'((b / 16) % 2);
      e.ampm = ((b / 32) % 2) == 1;
    end else begin
      e.d[5] = 4'((b / 16) % 4);
    end
    e.d[7]  = 4'((int'(r[3]) / 16) % 4);
    e.d[9]  = 4'((int'(r[4]) / 16) % 2);
    e.d[11] = 4'(int'(r[5]) / 16);
    e.d[13] = 4'((int'(r[6]) / 16) % 8);
    e.d[15] = 4'((int'(r[7]) / 16) % 8);
    e.d[17] = 4'((int'(r[8]) / 16) % 4);
    return e;
  endfunction

  // DUT 0 runs at T_PULSO=4 with full checking; 1 and 7 exercise the strobe timing limits
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int TP = (g == 0) ? 4 : ((g == 1) ? 1 : 7);
    rtc_lector_digitos_if bus();
    logic [3:0] dg [18];
    logic       ampm, fmt, hecho;
    logic [7:0] alat = 8'h00;
    int         rd_age = 0;

    // RTC model: latch address on wr_n, valid data from the 2nd read-strobe cycle on
    always @(posedge clock) begin
      if (!bus.wr_n && !bus.a_d) alat <= bus.ad_out;
      rd_age <= bus.rd_n ? 0 : rd_age + 1;
    end
    assign bus.ad_in = (!bus.rd_n && rd_age >= 1) ? mem[idx_of(alat)] : (mem[idx_of(alat)] ^ 8'hA5);

    rtc_lector_digitos #(.T_PULSO(TP)) dut (
      .clock(clock), .reset(reset), .leer((g == 0) ? leer : leer_x), .bus(bus.master),
      .digit0_SS(dg[0]),    .digit1_SS(dg[1]),    .digit0_MM(dg[2]),    .digit1_MM(dg[3]),
      .digit0_HH(dg[4]),    .digit1_HH(dg[5]),    .digit0_DAY(dg[6]),   .digit1_DAY(dg[7]),
      .digit0_MES(dg[8]),   .digit1_MES(dg[9]),   .digit0_YEAR(dg[10]), .digit1_YEAR(dg[11]),
      .digit0_SS_T(dg[12]), .digit1_SS_T(dg[13]), .digit0_MM_T(dg[14]), .digit1_MM_T(dg[15]),
      .digit0_HH_T(dg[16]), .digit1_HH_T(dg[17]),
      .AM_PM(ampm), .formato_hora(fmt), .hecho(hecho)
    );
  end

  function automatic disp_t act0();
    disp_t a;
    a = '0;
    for (int i = 0; i < 18; i++) a.d[i] = g_dut[0].dg[i];
    a.ampm = g_dut[0].ampm;
    a.fmt  = g_dut[0].fmt;
    return a;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // per-DUT bus checker state (monitor only)
  int  idx[3], wrun[3], rrun[3], slen[3], hcount[3];
  bit  sact[3];
  logic p_wr[3], p_rd[3], p_cs[3], p_oe[3], p_ad[3];

  task automatic bus_rst(input int k);
    idx[k] = 0; wrun[k] = 0; rrun[k] = 0; slen[k] = 0; sact[k] = 0;
    p_wr[k] = 1; p_rd[k] = 1; p_cs[k] = 1; p_oe[k] = 0; p_ad[k] = 1;
  endtask

  task automatic bus_chk(input int k, input int tp, input logic cs_n, input logic wr_n,
                         input logic rd_n, input logic ad_oe, input logic a_d,
                         input logic [7:0] ad_out, input logic hecho);
    if (!rd_n) chk("oe_vs_rd", ad_oe, 1'b0);
    if (!wr_n) begin
      chk("wr_addr", ad_out, addr_of(idx[k]));
      chk("wr_phase", {ad_oe, a_d, cs_n}, 3'b100);
      wrun[k]++;
    end else if (!p_wr[k]) begin
      chk("wr_width", wrun[k], tp);
      chk("addr_hold", {ad_oe, a_d, cs_n}, 3'b100);
      wrun[k] = 0;
    end
    if (!rd_n && p_rd[k]) chk("turnaround", {p_oe[k], p_ad[k], p_cs[k]}, 3'b010);
    if (!rd_n) rrun[k]++;
    else if (!p_rd[k]) begin
      chk("rd_width", rrun[k], tp);
      chk("d_end_cs", cs_n, 1'b1);
      rrun[k] = 0;
      idx[k] = (idx[k] + 1) % 9;
    end
    if (!cs_n && !a_d && ad_out == 8'h21 && p_cs[k]) begin
      sact[k] = 1; slen[k] = 1;
    end else if (sact[k]) slen[k]++;
    if (hecho) begin
      chk("sweep_len", slen[k], 9 * (2 * tp + 4) + 1);
      sact[k] = 0;
      hcount[k]++;
    end
    p_wr[k] = wr_n; p_rd[k] = rd_n; p_cs[k] = cs_n; p_oe[k] = ad_oe; p_ad[k] = a_d;
  endtask

  // monitor / scoreboard
  initial begin
    disp_t a, e;
    bit h_prev, pend;
    h_prev = 0; pend = 0; shown = '0;
    for (int k = 0; k < 3; k++) begin bus_rst(k); hcount[k] = 0; end
    forever begin
      @(negedge clock);
      if (!reset) begin
        chk("rst_bus", {g_dut[0].bus.cs_n, g_dut[0].bus.wr_n, g_dut[0].bus.rd_n,
                        g_dut[0].bus.ad_oe, g_dut[0].bus.a_d}, 5'b11101);
        chk("rst_ad_out", g_dut[0].bus.ad_out, 8'h00);
        chk("rst_hecho", g_dut[0].hecho, 1'b0);
        chk("rst_display", act0(), 80'h0);
        shown = '0; h_prev = 0; pend = 0;
        for (int k = 0; k < 3; k++) bus_rst(k);
      end else begin
        bus_chk(0, 4, g_dut[0].bus.cs_n, g_dut[0].bus.wr_n, g_dut[0].bus.rd_n,
                g_dut[0].bus.ad_oe, g_dut[0].bus.a_d, g_dut[0].bus.ad_out, g_dut[0].hecho);
        bus_chk(1, 1, g_dut[1].bus.cs_n, g_dut[1].bus.wr_n, g_dut[1].bus.rd_n,
                g_dut[1].bus.ad_oe, g_dut[1].bus.a_d, g_dut[1].bus.ad_out, g_dut[1].hecho);
        bus_chk(2, 7, g_dut[2].bus.cs_n, g_dut[2].bus.wr_n, g_dut[2].bus.rd_n,
                g_dut[2].bus.ad_oe, g_dut[2].bus.a_d, g_dut[2].bus.ad_out, g_dut[2].hecho);
        a = act0();
        if (g_dut[0].hecho) begin
          chk("hecho_expected", expq.size() > 0, 1'b1);
          if (expq.size() > 0) begin
            e = expq.pop_front();
            chk("display", a, e);
            shown = e;
          end
        end else begin
          chk("display_stable", a, shown);
        end
        if (pend) begin
          chk("b2b_restart", {g_dut[0].bus.cs_n, g_dut[0].bus.ad_out}, {1'b0, 8'h21});
          pend = 0;
        end
        if (h_prev) begin
          chk("idle_gap", g_dut[0].bus.cs_n, 1'b1);
          pend = leer;
        end
        h_prev = g_dut[0].hecho;
        if (done) begin
          chk("queue_drained", expq.size(), 0);
          chk("timeouts", timeouts, 0);
          chk("t1_sweeps", hcount[1] > 0, 1'b1);
          chk("t7_sweeps", hcount[2] > 0, 1'b1);
          $display("[TB] %0d tests run, %0d failed", tests, fails);
          $finish;
        end
      end
    end
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic poll_hecho();
    int n = 0;
    while (!g_dut[0].hecho && n < 500) begin step(); n++; end
    if (n >= 500) timeouts++;
  endtask

  task automatic poll_addr(input logic [7:0] a);
    int n = 0;
    while (!(g_dut[0].bus.a_d == 0 && g_dut[0].bus.cs_n == 0 && g_dut[0].bus.ad_out == a) && n < 500) begin
      step(); n++;
    end
    if (n >= 500) timeouts++;
  endtask

  task automatic poll_rd();
    int n = 0;
    while (g_dut[0].bus.rd_n && n < 500) begin step(); n++; end
    if (n >= 500) timeouts++;
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < 9; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_sweep();
    expq.push_back(model(mem));
    leer = 1; step(); leer = 0;
    poll_hecho(); step();
  endtask

  // stimulus
  initial begin
    repeat (3) @(posedge clock);
    #1 reset = 1; leer_x = 1;
    step();

    // known time: 23:47:59, 31/12/99
    randomize_mem();
    mem[0] = 8'h59; mem[1] = 8'h47; mem[2] = 8'h23;
    mem[3] = 8'h31; mem[4] = 8'h12; mem[5] = 8'h99;
    run_sweep();

    // 12 h mode, PM, 11 o'clock
    mem[2] = 8'hB1;
    run_sweep();

    repeat (6) begin
      randomize_mem();
      run_sweep();
      repeat ($urandom_range(0, 3)) step();
    end

    // reset in the middle of reading HH, then a fresh sweep from 21h
    randomize_mem();
    leer = 1; step(); leer = 0;
    poll_addr(8'h23);
    poll_rd();
    step();
    reset = 0;
    step(); step();
    reset = 1;
    step();
    randomize_mem();
    run_sweep();

    // three back-to-back sweeps, SS changes after it was read in the second one
    randomize_mem();
    mem[0] = 8'h10;
    expq.push_back(model(mem));
    leer = 1;
    poll_hecho();
    expq.push_back(model(mem));
    step();
    poll_addr(8'h22);
    mem[0] = 8'h11;
    expq.push_back(model(mem));
    poll_hecho(); step();
    poll_hecho();
    leer = 0;
    step();

    // leer pulse during a sweep is not queued
    randomize_mem();
    expq.push_back(model(mem));
    leer = 1; step(); leer = 0;
    repeat (40) step();
    leer = 1; step(); leer = 0;
    poll_hecho(); step();
    repeat (150) step();

    done = 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
